// File: rtl/ycbcr_conv_arbiter.sv
// Small synchronous FIFO with first-word fall-through output; write and read may share a cycle.
// Latency: a write is visible on rd_dat the next cycle. Backpressure: rd_rdy holds the head entry; the caller must never write when full.
module ycbcr_conv_fifo #(
    parameter int W     = 26,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          rd_en;

    assign rd_en  = rd_vld && rd_rdy;
    assign rd_vld = (count != '0);
    assign rd_dat = mem[rd_ptr];

    // Storage is cleared on reset so the output bus reads zero until the first write.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + (AW+1)'(wr_vld) - (AW+1)'(rd_en);
        end
    end
endmodule

// Two-source line-locked round-robin front end for a shared, non-stallable RGB->YCbCr pipeline.
// Latency: accept to FIFO write is CONV_LAT cycles, m_valid one cycle later. Backpressure: m_ready via reserved-slot credits.
module ycbcr_conv_arbiter #(
    parameter int CONV_LAT = 4,
    parameter int DEPTH    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        s0_valid,
    output logic        s0_ready,
    input  logic [23:0] s0_rgb,
    input  logic        s0_last,
    input  logic        s1_valid,
    output logic        s1_ready,
    input  logic [23:0] s1_rgb,
    input  logic        s1_last,
    output logic [7:0]  cv_r,
    output logic [7:0]  cv_g,
    output logic [7:0]  cv_b,
    input  logic [7:0]  cv_y,
    input  logic [7:0]  cv_cb,
    input  logic [7:0]  cv_cr,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [23:0] m_ycbcr,
    output logic        m_src,
    output logic        m_last,
    output logic        idle
);
    localparam int             CW      = $clog2(DEPTH + 1);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    typedef struct packed {
        logic vld;
        logic src;
        logic last;
    } tag_t;

    typedef struct packed {
        logic [23:0] ycbcr;
        logic        src;
        logic        last;
    } beat_t;

    state_t        state;
    state_t        state_nxt;
    logic          rr;
    logic          rr_nxt;
    logic [CW-1:0] reserved;
    logic          gnt0;
    logic          gnt1;
    logic          room;
    logic          pop;
    logic          acc0;
    logic          acc1;
    logic          acc;
    logic          acc_src;
    logic          acc_last;
    logic [23:0]   acc_rgb;
    tag_t          tag_pipe [CONV_LAT];
    tag_t          tag_out;
    beat_t         wr_beat;
    beat_t         rd_beat;

    assign pop  = m_valid && m_ready;
    // A pop in the same cycle frees a slot, so a full credit pool still sustains one beat per cycle.
    assign room = (reserved < DEPTH_C) || pop;

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        case (state)
            IDLE: begin
                if (s0_valid && (!s1_valid || !rr)) begin
                    gnt0 = 1'b1;
                end else if (s1_valid) begin
                    gnt1 = 1'b1;
                end
            end
            LOCK0:   gnt0 = 1'b1;
            LOCK1:   gnt1 = 1'b1;
            default: ;
        endcase
    end

    assign s0_ready = gnt0 && room && !rst;
    assign s1_ready = gnt1 && room && !rst;

    assign acc0     = s0_valid && s0_ready;
    assign acc1     = s1_valid && s1_ready;
    assign acc      = acc0 || acc1;
    assign acc_src  = acc1;
    assign acc_last = acc1 ? s1_last : s0_last;
    assign acc_rgb  = acc1 ? s1_rgb  : s0_rgb;

    always_comb begin
        state_nxt = state;
        rr_nxt    = rr;
        if (acc) begin
            if (acc_last) begin
                state_nxt = IDLE;
                rr_nxt    = ~acc_src;
            end else begin
                state_nxt = acc_src ? LOCK1 : LOCK0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            rr       <= 1'b0;
            reserved <= '0;
            cv_r     <= '0;
            cv_g     <= '0;
            cv_b     <= '0;
        end else begin
            state <= state_nxt;
            rr    <= rr_nxt;
            case ({acc, pop})
                2'b10:   reserved <= reserved + CW'(1);
                2'b01:   reserved <= reserved - CW'(1);
                default: ;
            endcase
            if (acc) begin
                {cv_r, cv_g, cv_b} <= acc_rgb;
            end
        end
    end

    // Tags travel alongside the pixel; clearing them on reset discards results still inside the converter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < CONV_LAT; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= {acc, acc_src, acc_last};
            for (int i = 1; i < CONV_LAT; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    assign tag_out = tag_pipe[CONV_LAT-1];
    assign wr_beat = {cv_y, cv_cb, cv_cr, tag_out.src, tag_out.last};

    ycbcr_conv_fifo #(
        .W     ($bits(beat_t)),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_vld (tag_out.vld),
        .wr_dat (wr_beat),
        .rd_vld (m_valid),
        .rd_rdy (m_ready),
        .rd_dat (rd_beat)
    );

    assign m_ycbcr = rd_beat.ycbcr;
    assign m_src   = rd_beat.src;
    assign m_last  = rd_beat.last;
    assign idle    = (state == IDLE) && (reserved == '0);
endmodule

// File: tb/tb_ycbcr_conv_arbiter.sv
// Bench for ycbcr_conv_arbiter: behavioural converter, directed scenarios, then random two-source traffic.
// Expected beats are queued at accept time and compared by an independent output monitor.
module tb_ycbcr_conv_arbiter;
    localparam int CONV_LAT = 4;
    localparam int DEPTH    = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        s0_valid, s0_ready, s0_last;
    logic [23:0] s0_rgb;
    logic        s1_valid, s1_ready, s1_last;
    logic [23:0] s1_rgb;
    logic [7:0]  cv_r, cv_g, cv_b, cv_y, cv_cb, cv_cr;
    logic        m_valid, m_ready, m_src, m_last, idle;
    logic [23:0] m_ycbcr;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    ycbcr_conv_arbiter #(.CONV_LAT(CONV_LAT), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_rgb(s0_rgb), .s0_last(s0_last),
        .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_rgb(s1_rgb), .s1_last(s1_last),
        .cv_r(cv_r), .cv_g(cv_g), .cv_b(cv_b),
        .cv_y(cv_y), .cv_cb(cv_cb), .cv_cr(cv_cr),
        .m_valid(m_valid), .m_ready(m_ready), .m_ycbcr(m_ycbcr),
        .m_src(m_src), .m_last(m_last), .idle(idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Integer BT.601 full-range conversion, clamped to 8 bits.
    function automatic logic [23:0] rgb2ycc(input logic [23:0] p);
        int r, g, b, y, cb, cr;
        r  = int'(p[23:16]);
        g  = int'(p[15:8]);
        b  = int'(p[7:0]);
        y  = (77 * r + 150 * g + 29 * b) >>> 8;
        cb = 128 + ((-43 * r - 85 * g + 128 * b) >>> 8);
        cr = 128 + ((128 * r - 107 * g - 21 * b) >>> 8);
        if (y  > 255) y  = 255; if (y  < 0) y  = 0;
        if (cb > 255) cb = 255; if (cb < 0) cb = 0;
        if (cr > 255) cr = 255; if (cr < 0) cr = 0;
        return {8'(y), 8'(cb), 8'(cr)};
    endfunction

    // Shared converter: cv_* register is the first stage, these are the remaining CONV_LAT-1; never reset.
    logic [23:0] cpipe [CONV_LAT-1];
    always @(posedge clk) begin
        cpipe[0] <= rgb2ycc({cv_r, cv_g, cv_b});
        for (int i = 1; i < CONV_LAT - 1; i++) cpipe[i] <= cpipe[i-1];
    end
    assign {cv_y, cv_cb, cv_cr} = cpipe[CONV_LAT-2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [25:0] exp_q [$];
    int          line_srcs [$];
    int          lock_m = -1;
    int          rr_m = 0;
    int          outstanding = 0;
    int          acc_cnt = 0;
    int          g_m;
    bit          pop_s, room_m, hold_vld = 0;
    logic [25:0] hold_dat, e;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            lock_m = -1; rr_m = 0; outstanding = 0; acc_cnt = 0; hold_vld = 0;
        end else begin
            pop_s = m_valid && m_ready;
            if (hold_vld) begin
                check("stall_valid", 32'(m_valid), 32'd1);
                check("stall_data", 32'({m_ycbcr, m_src, m_last}), 32'(hold_dat));
            end
            hold_vld = m_valid && !m_ready;
            hold_dat = {m_ycbcr, m_src, m_last};

            if (lock_m >= 0)               g_m = lock_m;
            else if (s0_valid && s1_valid) g_m = rr_m;
            else if (s0_valid)             g_m = 0;
            else if (s1_valid)             g_m = 1;
            else                           g_m = -1;
            room_m = (outstanding < DEPTH) || pop_s;
            check("s0_ready", 32'(s0_ready), 32'((g_m == 0) && room_m));
            check("s1_ready", 32'(s1_ready), 32'((g_m == 1) && room_m));
            check("idle", 32'(idle), 32'((lock_m < 0) && (outstanding == 0)));

            if (pop_s) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_err++;
                    $display("FAIL unexpected_out: got %0h src %0d, expected no output", m_ycbcr, m_src);
                end else begin
                    e = exp_q.pop_front();
                    check("out_ycbcr", 32'(m_ycbcr), 32'(e[25:2]));
                    check("out_src", 32'(m_src), 32'(e[1]));
                    check("out_last", 32'(m_last), 32'(e[0]));
                end
                if (m_last) line_srcs.push_back(int'(m_src));
                outstanding--;
            end
            if (s0_valid && s0_ready) begin
                exp_q.push_back({rgb2ycc(s0_rgb), 1'b0, s0_last});
                acc_cnt++; outstanding++;
                if (s0_last) begin lock_m = -1; rr_m = 1; end else lock_m = 0;
            end
            if (s1_valid && s1_ready) begin
                exp_q.push_back({rgb2ycc(s1_rgb), 1'b1, s1_last});
                acc_cnt++; outstanding++;
                if (s1_last) begin lock_m = -1; rr_m = 0; end else lock_m = 1;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int src, input logic v, input logic [23:0] d, input logic l);
        if (src == 0) begin s0_valid = v; s0_rgb = d; s0_last = l; end
        else          begin s1_valid = v; s1_rgb = d; s1_last = l; end
    endtask

    // Called at posedge+1; returns at posedge+1 after the line's last beat is accepted.
    task automatic send_line(input int src, input int n, input logic [23:0] rgb, input bit rnd, input bit gaps);
        int waited;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(3) == 0) begin
                drive(src, 1'b0, 24'd0, 1'b0);
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1;
            end
            drive(src, 1'b1, rnd ? 24'($urandom) : rgb, i == n - 1);
            waited = 0;
            do begin
                @(negedge clk);
                waited++;
            end while (!((src == 0) ? s0_ready : s1_ready) && waited < 300);
            if (!((src == 0) ? s0_ready : s1_ready)) begin
                n_cmp++; n_err++;
                $display("FAIL accept_timeout: src %0d beat %0d not accepted, expected accept", src, i);
            end
            @(posedge clk); #1;
        end
        drive(src, 1'b0, 24'd0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_ready", 32'({s0_ready, s1_ready}), 32'd0);
        check("rst_cv", 32'({cv_r, cv_g, cv_b}), 32'd0);
        check("rst_m_bus", 32'({m_ycbcr, m_src, m_last}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        line_srcs.delete();
        @(negedge clk);
        check("rst_idle", 32'(idle), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic wait_drain();
        int k;
        k = 0;
        do begin @(negedge clk); k++; end while (!(idle && !m_valid) && k < 500);
        check("drain_idle", 32'(idle && !m_valid), 32'd1);
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
    endtask

    // ---------------- directed + random scenarios ----------------
    int t_acc, t_out, k, cnt, code;
    bit done0, done1;

    initial begin
        rst = 1'b1; m_ready = 1'b1;
        drive(0, 1'b0, 24'd0, 1'b0);
        drive(1, 1'b0, 24'd0, 1'b0);
        repeat (2) @(posedge clk); #1;
        do_reset();

        // Single red line: latency, value and throughput.
        fork
            send_line(0, 8, 24'hFF0000, 1'b0, 1'b0);
            begin
                k = 0;
                do begin @(negedge clk); k++; end while (!(s0_valid && s0_ready) && k < 50);
                t_acc = cyc;
                k = 0;
                do begin @(negedge clk); k++; end while (!m_valid && k < 50);
                t_out = cyc;
                check("first_latency", 32'(t_out - t_acc), 32'd5);
                check("red_value", 32'(m_ycbcr), 32'h4C55FF);
                check("red_src", 32'(m_src), 32'd0);
                cnt = 0;
                for (int i = 0; i < 7; i++) begin @(negedge clk); if (m_valid) cnt++; end
                check("one_per_cycle", 32'(cnt), 32'd7);
            end
        join
        wait_drain();

        // Both sources saturating: line alternation starting with source 0.
        do_reset();
        fork
            begin send_line(0, 4, 24'h808080, 1'b0, 1'b0); send_line(0, 4, 24'h808080, 1'b0, 1'b0); end
            begin send_line(1, 4, 24'h000000, 1'b0, 1'b0); send_line(1, 4, 24'h000000, 1'b0, 1'b0); end
        join
        wait_drain();
        check("alt_lines", 32'(line_srcs.size()), 32'd4);
        if (line_srcs.size() >= 4) begin
            code = line_srcs[0] * 8 + line_srcs[1] * 4 + line_srcs[2] * 2 + line_srcs[3];
            check("alt_order", 32'(code), 32'd5);
        end

        // Backpressure fill to DEPTH, then steady state accept+pop at full credit.
        do_reset();
        m_ready = 1'b0;
        fork
            send_line(0, 12, 24'd0, 1'b1, 1'b0);
            begin
                repeat (30) @(negedge clk);
                check("fill_accepts", 32'(acc_cnt), 32'd8);
                check("fill_ready", 32'(s0_ready), 32'd0);
                @(posedge clk); #1;
                m_ready = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    @(negedge clk);
                    check("steady_ready", 32'(s0_ready), 32'd1);
                    check("steady_pop", 32'(m_valid), 32'd1);
                end
            end
        join
        wait_drain();

        // Reset mid-line with 3 beats in flight.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 1'b1, 24'($urandom), 1'b0);
            @(negedge clk);
            check("pre_rst_ready", 32'(s0_ready), 32'd1);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 32'd0);
        check("midrst_ready", 32'({s0_ready, s1_ready}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 1'b0, 24'd0, 1'b0);
        @(negedge clk);
        check("postrst_idle", 32'(idle), 32'd1);
        check("postrst_m_valid", 32'(m_valid), 32'd0);
        @(posedge clk); #1;
        send_line(1, 1, 24'd0, 1'b1, 1'b0);
        wait_drain();

        // Lock holds off source 1 until source 0's last beat; s1 granted next cycle.
        do_reset();
        fork
            send_line(0, 6, 24'd0, 1'b1, 1'b0);
            begin repeat (2) @(posedge clk); #1; send_line(1, 2, 24'd0, 1'b1, 1'b0); end
            begin
                k = 0;
                do begin @(negedge clk); k++; end while (!(s0_valid && s0_ready && s0_last) && k < 100);
                t_acc = cyc;
                k = 0;
                do begin @(negedge clk); k++; end while (!(s1_valid && s1_ready) && k < 100);
                t_out = cyc;
                check("lock_release", 32'(t_out - t_acc), 32'd1);
            end
        join
        wait_drain();

        // Random traffic with random gaps and downstream stalls.
        do_reset();
        done0 = 0; done1 = 0;
        fork
            begin
                for (int i = 0; i < 15; i++) send_line(0, $urandom_range(6, 1), 24'd0, 1'b1, 1'b1);
                done0 = 1;
            end
            begin
                for (int j = 0; j < 15; j++) send_line(1, $urandom_range(6, 1), 24'd0, 1'b1, 1'b1);
                done1 = 1;
            end
            begin
                while (!(done0 && done1)) begin
                    @(posedge clk); #1;
                    m_ready = ($urandom_range(7) > 2);
                end
                m_ready = 1'b1;
            end
        join
        wait_drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: simulation still running at cycle %0d, expected completion", cyc);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1);
    end
endmodule
